// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// layout, the fixed stall patterns and the drain FSM encoding.
package stall_ctrl_pkg;

   localparam int StallSignalLen = 6;

   // Bit k of the stall vector holds stage k.
   localparam int StallPC  = 0;
   localparam int StallIF  = 1;
   localparam int StallID  = 2;
   localparam int StallEX  = 3;
   localparam int StallMEM = 4;
   localparam int StallWB  = 5;

   typedef logic [StallSignalLen-1:0] stall_vec_t;

   // MEM busy: everything up to and including MEM holds, WB drains.
   localparam stall_vec_t StallPatMem      = 6'b011111;
   // Jump accepted: nothing holds, the wrong path is replaced by the target.
   localparam stall_vec_t StallPatJump     = 6'b000000;
   // Load-use: PC/IF/ID hold, id_ex receives a bubble.
   localparam stall_vec_t StallPatLoadUse  = 6'b000111;
   // No fetch available: PC/IF hold, if_id receives a bubble.
   localparam stall_vec_t StallPatFetch    = 6'b000011;
   localparam stall_vec_t StallPatNone     = 6'b000000;

   // RUN: normal flow. DRAIN: a wrong-path fetch is still outstanding.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational so the
// forwarding unit can reuse it.
module hazard_detect
   import stall_ctrl_pkg::*;
(
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_rs1_use_i,
   input  logic       id_rs2_use_i,
   output logic       lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real dependency, so a load to x0 never stalls.
   always_comb begin
      rs1_hit = id_rs1_use_i && (id_rs1_i == ex_rd_i);
      rs2_hit = id_rs2_use_i && (id_rs2_i == ex_rd_i);
      lu_o    = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/stall_ctrl.sv
// Central stall and flush controller: priority mux for the stall vector,
// RUN/DRAIN sequencing of a wrong-path fetch after a jump, and the
// stall-cycle / flush performance counters.
//
// Handshake note: stall_signal, jump_taken and discard_fetch are
// combinational and are sampled by their consumers on the same rising edge
// that updates this block's state; there is no valid/ready pairing here.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int FLUSH_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_stall_req,
   input  logic                      if_busy,
   input  logic                      mem_stall_req,
   input  logic                      ex_is_load,
   input  logic [4:0]                ex_rd,
   input  logic [4:0]                id_rs1,
   input  logic [4:0]                id_rs2,
   input  logic                      id_rs1_use,
   input  logic                      id_rs2_use,
   input  logic                      jump_flag,
   output logic [StallSignalLen-1:0] stall_signal,
   output logic                      jump_taken,
   output logic                      discard_fetch,
   output logic [CNT_W-1:0]          stall_cycles,
   output logic [FLUSH_W-1:0]        flush_count,
   output state_e                    fsm_state
);

   state_e             state_q;
   state_e             state_d;
   logic [CNT_W-1:0]   stall_cycles_q;
   logic [FLUSH_W-1:0] flush_count_q;
   logic               lu;
   logic               jump_ok;
   logic               in_drain;

   hazard_detect u_hazard_detect (
      .ex_is_load_i (ex_is_load),
      .ex_rd_i      (ex_rd),
      .id_rs1_i     (id_rs1),
      .id_rs2_i     (id_rs2),
      .id_rs1_use_i (id_rs1_use),
      .id_rs2_use_i (id_rs2_use),
      .lu_o         (lu)
   );

   // Stall priority mux and jump acceptance; a jump seen in DRAIN is ignored.
   always_comb begin
      in_drain   = (state_q == ST_DRAIN);
      jump_ok    = jump_flag && !in_drain;
      jump_taken = jump_ok && !mem_stall_req;
      // Pulse on the accepting cycle even if the fetch just completed, then
      // stay high for the whole DRAIN period.
      discard_fetch = in_drain || jump_taken;
      if (mem_stall_req) begin
         stall_signal = StallPatMem;
      end else if (jump_ok) begin
         stall_signal = StallPatJump;
      end else if (lu) begin
         stall_signal = StallPatLoadUse;
      end else if (if_stall_req || in_drain) begin
         stall_signal = StallPatFetch;
      end else begin
         stall_signal = StallPatNone;
      end
   end

   // Next-state logic for the wrong-path fetch drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (jump_taken && if_busy) state_d = ST_DRAIN;
         ST_DRAIN: if (!if_busy)              state_d = ST_RUN;
         default:                             state_d = ST_RUN;
      endcase
   end

   // FSM state register; reset drops any drain since IF is reset as well.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Stall-cycle counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
      end else if (stall_signal[StallPC] && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
   end

   // Flush counter: one count per accepted jump, wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_count_q <= '0;
      end else if (jump_taken) begin
         flush_count_q <= flush_count_q + FLUSH_W'(1);
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign fsm_state    = state_q;

   // ID and EX are bubbles while draining, so EX cannot resolve a jump then.
   jump_in_drain_a: assert property (@(posedge clk) disable iff (!rst)
      !(state_q == ST_DRAIN && jump_flag));

endmodule
